fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Consumer side of the multicycle program counter.
- Takes the current PC value and issues one instruction-memory read per instruction over a req/ack handshake.
- Holds the returned word for the decode stage under a valid/ready handshake.
- Emits a one-cycle pc_inc pulse that advances the counter only after decode has accepted the instruction.
- Sits between the PC register, instruction memory and the decode/control stage.

Parameters:
- AW, 5, PC/address width; equals the PC counter width.
- DW, 16, instruction word width.
- TMO, 8, max cycles to wait for mem_ack before aborting the fetch (TMO >= 2).

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous, active-low reset.
- en  input  1  fetch enable; new fetches launch only while high.
- flush  input  1  abort the current fetch and discard the held instruction.
- pc_addr  input  AW  current PC value from the counter.
- pc_inc  output  1  one-cycle pulse; counter increments on the following edge.
- mem_req  output  1  memory read request, level.
- mem_addr  output  AW  read address; stable while mem_req=1.
- mem_ack  input  1  memory response strobe; mem_rdata valid in the same cycle.
- mem_rdata  input  DW  read data.
- instr  output  DW  fetched instruction; stable while instr_valid=1.
- instr_valid  output  1  instr holds an unconsumed instruction.
- instr_ready  input  1  decode accepts instr when instr_valid and instr_ready are both high.
- fetch_err  output  1  one-cycle pulse on timeout.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (RST=0, async): state=IDLE; mem_req=0, mem_addr=0, instr=0, instr_valid=0, pc_inc=0, fetch_err=0, wait_cnt=0. All outputs are registered; busy is decoded from state.
- States: IDLE, REQ, HOLD.
- IDLE:
  - Launch condition: en=1, flush=0 and pc_inc=0.
  - On launch: mem_addr<=pc_addr, mem_req<=1, wait_cnt<=0, go REQ.
  - The pc_inc=0 guard ensures the counter has updated before the next address is sampled.
  - mem_ack in IDLE is ignored.
- REQ:
  - mem_req stays 1 and mem_addr is frozen.
  - If mem_ack=1: instr<=mem_rdata, instr_valid<=1, mem_req<=0, go HOLD.
  - Otherwise wait_cnt increments each cycle. When wait_cnt==TMO-1 and there is no ack: mem_req<=0, fetch_err<=1 for one cycle, go IDLE. No pc_inc is issued; the same address is retried on the next launch.
  - mem_ack on the last allowed cycle beats the timeout.
- HOLD:
  - instr_valid=1 and instr is stable.
  - On instr_ready=1: instr_valid<=0, pc_inc<=1, go IDLE.
  - instr keeps its last value after valid drops.
- pc_inc is high for exactly one cycle. It is never high in two consecutive cycles.
- flush (any state) has priority over mem_ack, instr_ready and launch in the same cycle:
  - Next state is IDLE; mem_req<=0, instr_valid<=0, no pc_inc, no fetch_err.
  - A mem_ack arriving after the flush is ignored.
  - The branch logic loads the PC externally while flush is high.
- en=0 only blocks new launches. An in-flight REQ/HOLD completes normally.
- Minimum throughput is 4 cycles/instruction with ack and ready immediate:
  - c0: IDLE launch.
  - c1: REQ with ack.
  - c2: HOLD with ready.
  - c3: IDLE, pc_inc=1, counter updates.
  - c4: next launch.
- wait_cnt width is clog2(TMO); it saturates and never wraps within REQ.
- Reset asserted mid-fetch returns to the reset values immediately; a pending ack is dropped.

Test Plan:
- Reset, then en=1, pc_addr=5'd0, mem_ack one cycle after mem_req, instr_ready=1 -> mem_addr=0, instr=mem_rdata (0xA5A5), pc_inc pulses; next launch uses pc_addr=1 and occurs exactly 4 cycles after the previous one.
- mem_ack delayed 3 cycles, instr_ready held low 5 cycles -> mem_req high exactly 4 cycles with mem_addr stable; instr_valid high 6 cycles with instr constant; single pc_inc after ready.
- No mem_ack with TMO=8 -> mem_req drops after 8 cycles, fetch_err pulses once, no pc_inc; relaunch with the same mem_addr.
- mem_ack on the 8th REQ cycle (TMO=8) -> fetch accepted, fetch_err stays 0.
- flush together with mem_ack in REQ, then flush together with instr_ready in HOLD -> both discarded: instr_valid stays/goes 0, no pc_inc, state IDLE; a late ack the next cycle is ignored.
- RST pulsed low while in HOLD, then en=0 -> all outputs reset; no launch until en=1; busy=0 throughout.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC -> imem req/ack -> decode valid/ready, then pc_inc.
// Latency: 4 cycles/instr minimum. Backpressure: holds instr until decode asserts instr_ready.
module fetch_sequencer #(
  parameter int AW  = 5,
  parameter int DW  = 16,
  parameter int TMO = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          en,
  input  logic          flush,
  input  logic [AW-1:0] pc_addr,
  output logic          pc_inc,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] instr,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic          fetch_err,
  output logic          busy
);

  localparam int CW = $clog2(TMO);
  localparam logic [CW-1:0] W_LAST = CW'(TMO - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_wait_cnt;
  logic          r_mem_req;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_instr;
  logic          r_instr_valid;
  logic          r_pc_inc;
  logic          r_fetch_err;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state       <= S_IDLE;
      r_wait_cnt    <= '0;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_pc_inc      <= 1'b0;
      r_fetch_err   <= 1'b0;
    end else begin
      r_pc_inc    <= 1'b0;
      r_fetch_err <= 1'b0;
      if (flush) begin
        r_state       <= S_IDLE;
        r_mem_req     <= 1'b0;
        r_instr_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            // Skip the pc_inc cycle so the counter has moved before we sample it.
            if (en && !r_pc_inc) begin
              r_mem_addr <= pc_addr;
              r_mem_req  <= 1'b1;
              r_wait_cnt <= '0;
              r_state    <= S_REQ;
            end
          end
          S_REQ: begin
            if (mem_ack) begin
              r_instr       <= mem_rdata;
              r_instr_valid <= 1'b1;
              r_mem_req     <= 1'b0;
              r_state       <= S_HOLD;
            end else if (r_wait_cnt == W_LAST) begin
              r_mem_req   <= 1'b0;
              r_fetch_err <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_wait_cnt <= r_wait_cnt + CW'(1);
            end
          end
          S_HOLD: begin
            if (instr_ready) begin
              r_instr_valid <= 1'b0;
              r_pc_inc      <= 1'b1;
              r_state       <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign pc_inc      = r_pc_inc;
  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign fetch_err   = r_fetch_err;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: memory/decode driven from tasks, returned words tracked in a queue.
module tb_fetch_sequencer;
  localparam int AW = 5;
  localparam int DW = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic          en, flush, mem_ack, instr_ready;
  logic [AW-1:0] pc_addr;
  logic [DW-1:0] mem_rdata;
  logic          pc_inc, mem_req, instr_valid, fetch_err, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] instr;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_inc   = 0;
  int n_err   = 0;
  logic [DW-1:0] sb[$];

  always #5 CLK = ~CLK;

  fetch_sequencer #(.AW(AW), .DW(DW), .TMO(8)) dut (
    .CLK(CLK), .RST(RST), .en(en), .flush(flush), .pc_addr(pc_addr), .pc_inc(pc_inc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .fetch_err(fetch_err), .busy(busy)
  );

  // Bench also plays the PC counter: it advances on the edge after pc_inc.
  task automatic tick;
    @(negedge CLK);
    cyc++;
    if (pc_inc === 1'b1) begin
      n_inc++;
      pc_addr = pc_addr + 1'b1;
    end
    if (fetch_err === 1'b1) n_err++;
  endtask

  task automatic serve(input int ack_dly, input int rdy_dly, input logic [DW-1:0] data,
                       output int launch, output logic [AW-1:0] addr, output int req_cyc,
                       output int vld_cyc, output bit addr_ok, output bit instr_ok,
                       output logic [DW-1:0] got, output bit ok);
    int w;
    ok = 0; req_cyc = 0; vld_cyc = 0; addr_ok = 1; instr_ok = 1;
    got = 'x; addr = 'x; launch = -1; w = 0;
    while (mem_req !== 1'b1 && w < 20) begin tick(); w++; end
    if (mem_req !== 1'b1) return;
    launch = cyc; addr = mem_addr; instr_ready = 1'b0;
    while (mem_req === 1'b1 && req_cyc < 40) begin
      if (mem_addr !== addr) addr_ok = 0;
      mem_ack   = (req_cyc == ack_dly);
      mem_rdata = data;
      if (mem_ack) sb.push_back(data);
      req_cyc++;
      tick();
      mem_ack = 1'b0;
    end
    if (instr_valid !== 1'b1) return;
    got = instr;
    while (instr_valid === 1'b1 && vld_cyc < 40) begin
      if (instr !== got) instr_ok = 0;
      instr_ready = (vld_cyc == rdy_dly);
      vld_cyc++;
      tick();
    end
    instr_ready = 1'b0;
    ok = 1;
  endtask

  int l0, l1, rc, vc, i0, e0;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] g, ex;
  bit aok, iok, ok;

  task automatic test_reset;
    n_tests++;
    if ({mem_req, instr_valid, pc_inc, fetch_err, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000", {mem_req, instr_valid, pc_inc, fetch_err, busy});
    end
    n_tests++;
    if (instr !== '0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", instr); end
    n_tests++;
    if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
  endtask

  task automatic test_back_to_back;
    en = 1'b1;
    i0 = n_inc;
    serve(0, 0, 16'hA5A5, l0, a0, rc, vc, aok, iok, g, ok);
    n_tests++;
    if (a0 !== 5'd0) begin n_fail++; $display("FAIL b2b_addr0: got %h want 0", a0); end
    ex = (sb.size() > 0) ? sb.pop_front() : 'x;
    n_tests++;
    if (!ok || g !== ex) begin n_fail++; $display("FAIL b2b_instr0: got %h want %h", g, ex); end
    n_tests++;
    if (n_inc - i0 != 1) begin n_fail++; $display("FAIL b2b_inc: got %0d want 1", n_inc - i0); end
    serve(0, 0, 16'h1111, l1, a1, rc, vc, aok, iok, g, ok);
    n_tests++;
    if (a1 !== 5'd1) begin n_fail++; $display("FAIL b2b_addr1: got %h want 1", a1); end
    n_tests++;
    if (l1 - l0 != 4) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 4", l1 - l0); end
    ex = (sb.size() > 0) ? sb.pop_front() : 'x;
    n_tests++;
    if (!ok || g !== ex) begin n_fail++; $display("FAIL b2b_instr1: got %h want %h", g, ex); end
  endtask

  task automatic test_slow_mem;
    i0 = n_inc;
    serve(3, 5, 16'h2222, l0, a0, rc, vc, aok, iok, g, ok);
    n_tests++;
    if (rc != 4 || !aok) begin n_fail++; $display("FAIL slow_req: got %0d cycles stable=%0d want 4 stable=1", rc, aok); end
    n_tests++;
    if (vc != 6 || !iok) begin n_fail++; $display("FAIL slow_valid: got %0d cycles stable=%0d want 6 stable=1", vc, iok); end
    ex = (sb.size() > 0) ? sb.pop_front() : 'x;
    n_tests++;
    if (!ok || g !== ex) begin n_fail++; $display("FAIL slow_instr: got %h want %h", g, ex); end
    n_tests++;
    if (n_inc - i0 != 1) begin n_fail++; $display("FAIL slow_inc: got %0d want 1", n_inc - i0); end
  endtask

  task automatic test_timeout;
    i0 = n_inc; e0 = n_err;
    serve(100, 0, 16'h0BAD, l0, a0, rc, vc, aok, iok, g, ok);
    n_tests++;
    if (rc != 8 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL tmo_req: got %0d cycles valid=%b want 8 valid=0", rc, instr_valid);
    end
    n_tests++;
    if (n_err - e0 != 1 || n_inc != i0) begin
      n_fail++; $display("FAIL tmo_pulses: got err=%0d inc=%0d want err=1 inc=0", n_err - e0, n_inc - i0);
    end
    serve(0, 0, 16'h3333, l1, a1, rc, vc, aok, iok, g, ok);
    n_tests++;
    if (a1 !== a0) begin n_fail++; $display("FAIL tmo_retry_addr: got %h want %h", a1, a0); end
    ex = (sb.size() > 0) ? sb.pop_front() : 'x;
    n_tests++;
    if (!ok || g !== ex) begin n_fail++; $display("FAIL tmo_retry_instr: got %h want %h", g, ex); end
  endtask

  task automatic test_ack_last;
    e0 = n_err;
    serve(7, 0, 16'h4444, l0, a0, rc, vc, aok, iok, g, ok);
    n_tests++;
    if (!ok || rc != 8 || n_err != e0) begin
      n_fail++; $display("FAIL ack_last: got ok=%0d cycles=%0d err=%0d want 1 8 0", ok, rc, n_err - e0);
    end
    ex = (sb.size() > 0) ? sb.pop_front() : 'x;
    n_tests++;
    if (g !== ex) begin n_fail++; $display("FAIL ack_last_instr: got %h want %h", g, ex); end
  endtask

  task automatic test_flush;
    int w;
    w = 0;
    while (mem_req !== 1'b1 && w < 20) begin tick(); w++; end
    i0 = n_inc;
    flush = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hDEAD; pc_addr = 5'h10;
    tick();
    flush = 1'b0;
    n_tests++;
    if ({instr_valid, busy, mem_req} !== 3'b000) begin
      n_fail++; $display("FAIL flush_req: got valid/busy/req=%b want 000", {instr_valid, busy, mem_req});
    end
    tick();
    mem_ack = 1'b0;
    n_tests++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 5'h10) begin
      n_fail++; $display("FAIL flush_late_ack: got valid=%b req=%b addr=%h want 0 1 10", instr_valid, mem_req, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    mem_ack = 1'b0;
    flush = 1'b1; instr_ready = 1'b1;
    tick();
    flush = 1'b0; instr_ready = 1'b0;
    n_tests++;
    if ({instr_valid, pc_inc, busy} !== 3'b000) begin
      n_fail++; $display("FAIL flush_hold: got valid/inc/busy=%b want 000", {instr_valid, pc_inc, busy});
    end
    tick();
    n_tests++;
    if (n_inc != i0) begin n_fail++; $display("FAIL flush_inc: got %0d want 0", n_inc - i0); end
  endtask

  task automatic test_reset_mid;
    int w;
    bit bad;
    w = 0;
    while (mem_req !== 1'b1 && w < 20) begin tick(); w++; end
    mem_ack = 1'b1; mem_rdata = 16'h5555;
    tick();
    mem_ack = 1'b0;
    n_tests++;
    if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL mid_hold: got valid=%b want 1", instr_valid); end
    #2;
    RST = 1'b0; en = 1'b0; mem_ack = 1'b1;
    #1;
    n_tests++;
    if ({mem_req, instr_valid, pc_inc, fetch_err, busy} !== 5'b0 || instr !== '0 || mem_addr !== '0) begin
      n_fail++; $display("FAIL mid_reset: got ctrl=%b instr=%h addr=%h want 0 0 0",
                         {mem_req, instr_valid, pc_inc, fetch_err, busy}, instr, mem_addr);
    end
    tick();
    RST = 1'b1; mem_ack = 1'b0;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (busy !== 1'b0 || mem_req !== 1'b0) bad = 1;
    end
    n_tests++;
    if (bad) begin n_fail++; $display("FAIL mid_idle: got busy/req while en=0 want none"); end
    en = 1'b1;
    tick();
    n_tests++;
    if (mem_req !== 1'b1 || mem_addr !== pc_addr || busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_relaunch: got req=%b addr=%h want 1 %h", mem_req, mem_addr, pc_addr);
    end
  endtask

  initial begin
    RST = 1'b0; en = 1'b0; flush = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0;
    pc_addr = '0; mem_rdata = '0;
    tick(); tick();
    test_reset();
    RST = 1'b1;
    tick();
    test_back_to_back();
    test_slow_mem();
    test_timeout();
    test_ack_last();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
